id_stage: RTL and testbench

Instruction-decode stage of the 5-stage 8-bit pipeline. It sits between IF_ID and ID_EX and owns the 32×8 register file. It decodes the 32-bit instruction into WB/M/EX control bundles, sign-extends the immediate, and detects load-use hazards. On a hazard it inserts a bubble into ID_EX and stalls PC and IF_ID. Every output feeds the same-named ID_EX input directly.

---
 rtl/cpu_pkg.sv | 33 +++
 rtl/reg_file.sv | 59 +++++
 rtl/id_stage.sv | 134 +++++++++++++
 tb/tb_id_stage.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit five-stage pipeline.
// Holds the opcode constants, the bit positions inside the WB/M/EX
// control bundles, and the register-file data and address widths.
package cpu_pkg;

    localparam int DW = 8;  // register data width
    localparam int AW = 5;  // register address width

    // Opcodes, instr[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // EX bundle bit positions
    localparam int ALUSRC     = 0;
    localparam int ALUOP0     = 1;
    localparam int ALUOP1     = 2;
    localparam int REGDST     = 3;

    // M bundle bit positions
    localparam int MEMWRITE   = 0;
    localparam int MEMREAD    = 1;
    localparam int BRANCHFLIP = 2;
    localparam int BRANCH     = 3;

    // WB bundle bit positions
    localparam int REGWRITE   = 0;
    localparam int MEMTOREG   = 1;

endpackage

// File: rtl/reg_file.sv
// Architectural register file: NREGS x DW, two combinational read ports,
// one write port committing on the rising clock edge.
// r0 is hard-wired to zero. A write being presented in the current cycle
// is forwarded straight to a matching read port, so a reader in ID sees
// the value being written back this cycle.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset (clears all regs)
//   ra1_i, ra2_i   read addresses
//   rd1_o, rd2_o   read data
//   we_i           write enable
//   wa_i, wd_i     write address and data
module reg_file #(
    parameter int NREGS = 32,
    parameter int DW    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [cpu_pkg::AW-1:0] ra1_i,
    input  logic [cpu_pkg::AW-1:0] ra2_i,
    output logic [DW-1:0]          rd1_o,
    output logic [DW-1:0]          rd2_o,
    input  logic                   we_i,
    input  logic [cpu_pkg::AW-1:0] wa_i,
    input  logic [DW-1:0]          wd_i
);

    logic [DW-1:0] regs_q [NREGS];

    // Reset has priority, so a write presented during reset is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (wa_i != '0)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    logic byp1, byp2;
    assign byp1 = we_i && (wa_i != '0) && (wa_i == ra1_i);
    assign byp2 = we_i && (wa_i != '0) && (wa_i == ra2_i);

    always_comb begin
        rd1_o = '0;
        if (ra1_i != '0) begin
            rd1_o = byp1 ? wd_i : regs_q[ra1_i];
        end
    end

    always_comb begin
        rd2_o = '0;
        if (ra2_i != '0) begin
            rd2_o = byp2 ? wd_i : regs_q[ra2_i];
        end
    end

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage. Decodes the IF_ID instruction into WB/M/EX
// control bundles, sign-extends the immediate, reads the register file and
// detects load-use hazards. On a hazard the control bundles are zeroed
// (a bubble goes into ID_EX) and stall holds PC and IF_ID for one cycle.
// All outputs are combinational; ID_EX samples them on the next edge.
//
// Ports:
//   clk, rst                 clock, async active-high reset (clears regfile)
//   instr, pcplus4_in        instruction and PC+4 from IF_ID
//   wb_we, wb_addr, wb_data  write-back port from MEM_WB
//   idex_memread, idex_rt    MemRead and rt of the instruction now in EX
//   WB, M, EX                control bundles for ID_EX
//   pcplus4                  PC+4 passthrough
//   read_data1, read_data2   rs / rt register values (with write-through)
//   imm32                    sign-extended instr[15:0]
//   rt, rd                   instr[20:16], instr[15:11]
//   stall                    hold PC and IF_ID this cycle
//   illegal                  opcode not decoded (suppressed during a bubble)
module id_stage #(
    parameter int NREGS = 32,
    parameter int DW    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            instr,
    input  logic [31:0]            pcplus4_in,
    input  logic                   wb_we,
    input  logic [cpu_pkg::AW-1:0] wb_addr,
    input  logic [DW-1:0]          wb_data,
    input  logic                   idex_memread,
    input  logic [cpu_pkg::AW-1:0] idex_rt,
    output logic [1:0]             WB,
    output logic [3:0]             M,
    output logic [3:0]             EX,
    output logic [31:0]            pcplus4,
    output logic [DW-1:0]          read_data1,
    output logic [DW-1:0]          read_data2,
    output logic [31:0]            imm32,
    output logic [cpu_pkg::AW-1:0] rt,
    output logic [cpu_pkg::AW-1:0] rd,
    output logic                   stall,
    output logic                   illegal
);

    import cpu_pkg::*;

    logic [5:0]    opcode;
    logic [AW-1:0] rs;

    assign opcode  = instr[31:26];
    assign rs      = instr[25:21];
    assign rt      = instr[20:16];
    assign rd      = instr[15:11];
    assign imm32   = {{16{instr[15]}}, instr[15:0]};
    assign pcplus4 = pcplus4_in;

    reg_file #(
        .NREGS (NREGS),
        .DW    (DW)
    ) u_reg_file (
        .clk   (clk),
        .rst   (rst),
        .ra1_i (rs),
        .ra2_i (rt),
        .rd1_o (read_data1),
        .rd2_o (read_data2),
        .we_i  (wb_we),
        .wa_i  (wb_addr),
        .wd_i  (wb_data)
    );

    // Main decoder.
    logic [1:0] wb_dec;
    logic [3:0] m_dec;
    logic [3:0] ex_dec;
    logic       illegal_dec;
    logic       reads_rt;   // instruction consumes rt as a source operand

    always_comb begin
        wb_dec      = '0;
        m_dec       = '0;
        ex_dec      = '0;
        illegal_dec = 1'b0;
        reads_rt    = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                wb_dec[REGWRITE] = 1'b1;
                ex_dec[REGDST]   = 1'b1;
                ex_dec[ALUOP1]   = 1'b1;
                reads_rt         = 1'b1;
            end
            OP_LW: begin
                wb_dec[REGWRITE] = 1'b1;
                wb_dec[MEMTOREG] = 1'b1;
                m_dec[MEMREAD]   = 1'b1;
                ex_dec[ALUSRC]   = 1'b1;
            end
            OP_SW: begin
                m_dec[MEMWRITE]  = 1'b1;
                ex_dec[ALUSRC]   = 1'b1;
                reads_rt         = 1'b1;
            end
            OP_BEQ: begin
                m_dec[BRANCH]    = 1'b1;
                ex_dec[ALUOP0]   = 1'b1;
                reads_rt         = 1'b1;
            end
            OP_BNE: begin
                m_dec[BRANCH]     = 1'b1;
                m_dec[BRANCHFLIP] = 1'b1;
                ex_dec[ALUOP0]    = 1'b1;
                reads_rt          = 1'b1;
            end
            OP_ADDI: begin
                wb_dec[REGWRITE] = 1'b1;
                ex_dec[ALUSRC]   = 1'b1;
            end
            default: begin
                illegal_dec = 1'b1;
            end
        endcase
    end

    // Load-use hazard: the load in EX targets a register this instruction
    // reads. lw/addi only read rs, so an rt match alone does not stall them.
    assign stall = idex_memread && (idex_rt != '0) &&
                   ((idex_rt == rs) || ((idex_rt == rt) && reads_rt));

    assign WB      = stall ? 2'b00 : wb_dec;
    assign M       = stall ? 4'b0000 : m_dec;
    assign EX      = stall ? 4'b0000 : ex_dec;
    assign illegal = stall ? 1'b0 : illegal_dec;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage. Each cycle the bench drives inputs in the low clock
// phase, computes the expected outputs from its own model (register array
// plus decode table) and pushes them to a queue; after settling it pops
// and compares field by field. Model writes commit on the rising edge.
module tb_id_stage;

    localparam int W = 102;  // packed expected-output width

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic [31:0] pcplus4_in;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [7:0]  wb_data;
    logic        idex_memread;
    logic [4:0]  idex_rt;
    logic [1:0]  WB;
    logic [3:0]  M;
    logic [3:0]  EX;
    logic [31:0] pcplus4;
    logic [7:0]  read_data1;
    logic [7:0]  read_data2;
    logic [31:0] imm32;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        stall;
    logic        illegal;

    id_stage dut (
        .clk          (clk),
        .rst          (rst),
        .instr        (instr),
        .pcplus4_in   (pcplus4_in),
        .wb_we        (wb_we),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .idex_memread (idex_memread),
        .idex_rt      (idex_rt),
        .WB           (WB),
        .M            (M),
        .EX           (EX),
        .pcplus4      (pcplus4),
        .read_data1   (read_data1),
        .read_data2   (read_data2),
        .imm32        (imm32),
        .rt           (rt),
        .rd           (rd),
        .stall        (stall),
        .illegal      (illegal)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic [7:0]   model_regs [32];
    int           n_cmp = 0;
    int           n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs_f,
                                       input logic [4:0] rt_f, input logic [15:0] imm);
        return {op, rs_f, rt_f, imm};
    endfunction

    // {WB, M, EX} for an opcode, plus illegal and reads-rt flags
    function automatic logic [11:0] decode_ref(input logic [5:0] op);
        case (op)
            6'b000000: return {2'b01, 4'b0000, 4'b1100, 1'b0, 1'b1};
            6'b100011: return {2'b11, 4'b0010, 4'b0001, 1'b0, 1'b0};
            6'b101011: return {2'b00, 4'b0001, 4'b0001, 1'b0, 1'b1};
            6'b000100: return {2'b00, 4'b1000, 4'b0010, 1'b0, 1'b1};
            6'b000101: return {2'b00, 4'b1100, 4'b0010, 1'b0, 1'b1};
            6'b001000: return {2'b01, 4'b0000, 4'b0001, 1'b0, 1'b0};
            default:   return {2'b00, 4'b0000, 4'b0000, 1'b1, 1'b0};
        endcase
    endfunction

    function automatic logic [7:0] read_ref(input logic [4:0] a);
        if (a == 5'd0) return 8'h00;
        if (wb_we && wb_addr == a) return wb_data;
        return model_regs[a];
    endfunction

    // ---------------- driver ----------------
    task automatic cycle(input logic r, input logic [31:0] ins, input logic we,
                         input logic [4:0] wa, input logic [7:0] wd,
                         input logic mr, input logic [4:0] irt);
        logic [11:0]  dec;
        logic         stl;
        logic [4:0]   rs_f;
        logic [4:0]   rt_f;
        logic [W-1:0] e;
        logic [W-1:0] got;
        @(negedge clk);
        rst          = r;
        instr        = ins;
        pcplus4_in   = $urandom;
        wb_we        = we;
        wb_addr      = wa;
        wb_data      = wd;
        idex_memread = mr;
        idex_rt      = irt;
        if (r) begin
            for (int i = 0; i < 32; i++) model_regs[i] = 8'h00;
        end
        rs_f = ins[25:21];
        rt_f = ins[20:16];
        dec  = decode_ref(ins[31:26]);
        stl  = mr && (irt != 0) && ((irt == rs_f) || ((irt == rt_f) && dec[0]));
        e = {stl ? 1'b0 : dec[1], stl,
             stl ? 10'd0 : dec[11:2],
             read_ref(rs_f), read_ref(rt_f), rt_f, ins[15:11],
             {{16{ins[15]}}, ins[15:0]}, pcplus4_in};
        exp_q.push_back(e);
        #2;
        if (exp_q.size() == 0) begin
            check("queue_empty", 32'd1, 32'd0);
        end else begin
            e   = exp_q.pop_front();
            got = {illegal, stall, WB, M, EX, read_data1, read_data2, rt, rd, imm32, pcplus4};
            check("illegal", {31'd0, got[101]},   {31'd0, e[101]});
            check("stall",   {31'd0, got[100]},   {31'd0, e[100]});
            check("WB",      {30'd0, got[99:98]}, {30'd0, e[99:98]});
            check("M",       {28'd0, got[97:94]}, {28'd0, e[97:94]});
            check("EX",      {28'd0, got[93:90]}, {28'd0, e[93:90]});
            check("rd1",     {24'd0, got[89:82]}, {24'd0, e[89:82]});
            check("rd2",     {24'd0, got[81:74]}, {24'd0, e[81:74]});
            check("rt",      {27'd0, got[73:69]}, {27'd0, e[73:69]});
            check("rd",      {27'd0, got[68:64]}, {27'd0, e[68:64]});
            check("imm32",   got[63:32],          e[63:32]);
            check("pcplus4", got[31:0],           e[31:0]);
        end
        @(posedge clk);
        if (!r && we && wa != 5'd0) model_regs[wa] = wd;
    endtask

    // ---------------- stimulus ----------------
    localparam logic [5:0] OPS [7] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                                       6'b000101, 6'b001000, 6'b111111};

    initial begin
        for (int i = 0; i < 32; i++) model_regs[i] = 8'h00;
        rst = 1'b1; instr = '0; pcplus4_in = '0; wb_we = 0; wb_addr = 0;
        wb_data = 0; idex_memread = 0; idex_rt = 0;

        // Reset state: instr=0 decodes as R-type, reads zero
        cycle(1, 32'h0, 0, 0, 8'h00, 0, 0);
        // Write r7=0x55 (bypassed), then read it registered
        cycle(0, mk(6'b000000, 5'd7, 5'd0, 16'h0), 1, 5'd7, 8'h55, 0, 0);
        cycle(0, mk(6'b000000, 5'd7, 5'd7, 16'h0), 0, 0, 8'h00, 0, 0);
        // Reset mid-cycle clears r7 before the next edge; write to r9 is dropped
        cycle(1, mk(6'b000000, 5'd7, 5'd0, 16'h0), 1, 5'd9, 8'h11, 0, 0);
        cycle(0, mk(6'b000000, 5'd9, 5'd7, 16'h0), 0, 0, 8'h00, 0, 0);
        // Write/bypass r5=0x3C, then registered read
        cycle(0, mk(6'b000000, 5'd5, 5'd1, 16'h0), 1, 5'd5, 8'h3C, 0, 0);
        cycle(0, mk(6'b000000, 5'd5, 5'd1, 16'h0), 0, 0, 8'h00, 0, 0);
        // Write to r0 is discarded
        cycle(0, mk(6'b000000, 5'd0, 5'd0, 16'h0), 1, 5'd0, 8'hFF, 0, 0);
        cycle(0, mk(6'b000000, 5'd0, 5'd0, 16'h0), 0, 0, 8'h00, 0, 0);
        // Decode sweep
        cycle(0, mk(6'b100011, 5'd5, 5'd2, 16'h8004), 0, 0, 8'h00, 0, 0);
        cycle(0, mk(6'b000101, 5'd5, 5'd2, 16'h0010), 0, 0, 8'h00, 0, 0);
        cycle(0, mk(6'b111111, 5'd1, 5'd2, 16'h7FFF), 0, 0, 8'h00, 0, 0);
        // Load-use on rt, then the load leaves EX
        cycle(0, mk(6'b000000, 5'd1, 5'd3, 16'h2000), 0, 0, 8'h00, 1, 5'd3);
        cycle(0, mk(6'b000000, 5'd1, 5'd3, 16'h2000), 0, 0, 8'h00, 0, 5'd3);
        // Exclusions: addi rt match, idex_rt=0
        cycle(0, mk(6'b001000, 5'd4, 5'd3, 16'h0001), 0, 0, 8'h00, 1, 5'd3);
        cycle(0, mk(6'b000000, 5'd0, 5'd0, 16'h0), 0, 0, 8'h00, 1, 5'd0);
        // Illegal opcode under a bubble
        cycle(0, mk(6'b111111, 5'd6, 5'd2, 16'h0), 0, 0, 8'h00, 1, 5'd6);
        // Priority: stall and bypass on the same register
        cycle(0, mk(6'b000000, 5'd5, 5'd8, 16'h0), 1, 5'd5, 8'hA7, 1, 5'd5);
        // rs==rt both bypassed
        cycle(0, mk(6'b101011, 5'd12, 5'd12, 16'h0), 1, 5'd12, 8'h9E, 0, 0);

        // Random traffic
        for (int n = 0; n < 60; n++) begin
            cycle(0,
                  mk(OPS[$urandom_range(0, 6)], 5'($urandom_range(0, 31)),
                     5'($urandom_range(0, 31)), 16'($urandom)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 8'($urandom),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
